scope_sync_fifo: RTL
====================

// Module: scope_sync_fifo
// PURPOSE
//  Single-clock FIFO with parametrised width and depth, for sample buffering between the ADC capture
//  path and the trigger/display logic of the oscilloscope.
//  Adds behaviour over the plain IP FIFO:
//   - selectable first-word-fall-through (FWFT) read mode
//   - parameterised almost-full/almost-empty thresholds
//   - synchronous flush
//   - sticky overflow/underflow error flags
//  Memory is inferred (registered read); no vendor primitive is instantiated.
// PARAMETERS
//  DATA_WIDTH        8     width of wr_data/rd_data (1..256)
//  DEPTH_WIDTH       10    log2 of capacity; DEPTH = 2**DEPTH_WIDTH words (4..16)
//  FWFT              0     0 = standard read (data 1 cycle after rd_en); 1 = first-word-fall-through
//  ALMOST_FULL_NUM   1020  almost_full when water_level >= this value (1..DEPTH)
//  ALMOST_EMPTY_NUM  4     almost_empty when water_level <= this value (0..DEPTH-1)
// PORTS
//  clk           in   1              single clock, rising edge
//  rst           in   1              asynchronous reset, active-high
//  flush         in   1              synchronous clear of contents and flags
//  wr_en         in   1              write request
//  wr_data       in   DATA_WIDTH     write data
//  wr_full       out  1              no further write accepted
//  almost_full   out  1              water_level >= ALMOST_FULL_NUM
//  rd_en         in   1              read request (FWFT: acknowledge of word on rd_data)
//  rd_data       out  DATA_WIDTH     read data
//  rd_empty      out  1              no readable word
//  almost_empty  out  1              water_level <= ALMOST_EMPTY_NUM
//  water_level   out  DEPTH_WIDTH+1  words held (accepted writes minus accepted reads)
//  overflow      out  1              sticky: write attempted while wr_full
//  underflow     out  1              sticky: read attempted while rd_empty
// BEHAVIOUR
//  Reset (rst=1, async)
//   - pointers = 0, water_level = 0, rd_data = 0
//   - rd_empty = 1, almost_empty = 1, wr_full = 0, almost_full = 0, overflow = 0, underflow = 0
//   - a reset mid-operation discards all contents.
//  Pointers
//   - DEPTH_WIDTH+1 bits, binary; the MSB distinguishes full from empty; they wrap modulo 2*DEPTH.
//  Write accept = wr_en & ~wr_full
//   - stores wr_data at wr_ptr and increments wr_ptr.
//   - wr_en & wr_full: data dropped, pointers unchanged, overflow <= 1.
//  Read accept = rd_en & ~rd_empty
//   - rd_en & rd_empty: pointers unchanged, rd_data holds, underflow <= 1.
//  Full handling
//   - wr_full is flag-based: a write in the same cycle as a read while full is still rejected
//     (overflow set); the read is accepted.
//   - an empty-cycle write+read: write accepted, read rejected (underflow set).
//  water_level
//   - +1 on write accept, -1 on read accept, unchanged when both occur.
//   - all flags are registered and derived from the next-state level, so they update on the same
//     edge as water_level.
//  Standard mode (FWFT=0)
//   - rd_data <= mem[rd_ptr] on the accept edge, i.e. valid 1 cycle after rd_en.
//   - rd_empty = (level==0); wr_full = (level==DEPTH).
//  FWFT mode (FWFT=1)
//   - head word is prefetched into the output register.
//   - rd_empty=0 means rd_data already holds the head word; rd_en pops it, and the next word
//     (if any) appears 1 cycle later with no bubble during continuous reads.
//   - a word written into an empty FIFO at edge N shows on rd_data with rd_empty=0 after edge N+2.
//   - water_level counts the word held in the output register.
//   - wr_full = (level==DEPTH).
//  Flush (synchronous, highest priority over wr_en/rd_en in the same cycle)
//   - pointers and level go to 0, rd_empty = 1, wr_full = 0, overflow = underflow = 0.
//   - rd_data holds its value; the FWFT output register is invalidated.
//  Sticky flags clear only on rst or flush.
// TESTING
//  1. Fill from empty: after rst, 1024 writes of data 0xFF down to 0x00 (wrapping)
//     -> almost_full rises after the 1020th write, wr_full after the 1024th, water_level = 1024.
//  2. Drain: 1024 reads (FWFT=0)
//     -> rd_data = 0xFF, 0xFE, ... each 1 cycle after rd_en.
//     -> almost_empty after level reaches 4, rd_empty after the last read, water_level = 0.
//  3. Errors: 1025th write while full -> overflow = 1, level stays 1024.
//     Read while empty -> underflow = 1, rd_data unchanged. Both clear on flush.
//  4. Simultaneous traffic: at level 512, 200 cycles of wr_en = rd_en = 1
//     -> level stays 512, output data order intact across pointer wrap.
//  5. Flush with wr_en = 1 at level 300 -> next cycle level = 0, rd_empty = 1, the write is discarded.
//     Then rst pulse mid-write burst -> all outputs at reset values immediately.
//  6. FWFT=1: single write of 0xA5 into empty FIFO -> rd_data = 0xA5, rd_empty = 0 two edges later.
//     Then continuous rd_en over 16 queued words -> one word per cycle, no bubble.

Source files
------------

// File: rtl/scope_sync_fifo.sv
// scope_sync_fifo: single-clock sample FIFO between ADC capture and trigger/display logic.
// Optional first-word-fall-through read, almost thresholds, synchronous flush, sticky error flags.
module scope_sync_fifo #(
  parameter int DATA_WIDTH       = 8,
  parameter int DEPTH_WIDTH      = 10,
  parameter int FWFT             = 0,
  parameter int ALMOST_FULL_NUM  = 1020,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_empty,
  output logic                  almost_empty,
  output logic [DEPTH_WIDTH:0]  water_level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int            PW       = DEPTH_WIDTH + 1;
  localparam int            DEPTH    = 1 << DEPTH_WIDTH;
  localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);
  localparam logic [PW-1:0] AF_LVL   = PW'(ALMOST_FULL_NUM);
  localparam logic [PW-1:0] AE_LVL   = PW'(ALMOST_EMPTY_NUM);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         level_q, level_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_empty_q, rd_empty_d;
  logic                  wr_full_q, wr_full_d;
  logic                  almost_full_q, almost_full_d;
  logic                  almost_empty_q, almost_empty_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc_s;
  logic                  rd_acc_s;

  // Write side, level bookkeeping and flags common to both read modes
  always_comb begin
    wr_acc_s    = wr_en & ~wr_full_q & ~flush;
    rd_acc_s    = rd_en & ~rd_empty_q & ~flush;
    wr_ptr_d    = wr_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      wr_ptr_d    = PTR_ZERO;
      level_d     = PTR_ZERO;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (wr_en & wr_full_q) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
      if (rd_en & rd_empty_q) begin
        underflow_d = 1'b1;
      end else begin
        underflow_d = underflow_q;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   level_d = level_q + PTR_ONE;
        2'b01:   level_d = level_q - PTR_ONE;
        default: level_d = level_q;
      endcase
    end
    wr_full_d      = (level_d == FULL_LVL);
    almost_full_d  = (level_d >= AF_LVL);
    almost_empty_d = (level_d <= AE_LVL);
  end

  if (FWFT == 0) begin : g_std
    // Standard read: the accepted read loads mem[rd_ptr] into the output register
    always_comb begin
      rd_ptr_d  = rd_ptr_q;
      rd_data_d = rd_data_q;
      if (flush) begin
        rd_ptr_d = PTR_ZERO;
      end else if (rd_acc_s) begin
        rd_ptr_d  = rd_ptr_q + PTR_ONE;
        rd_data_d = mem[rd_ptr_q[DEPTH_WIDTH-1:0]];
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      rd_empty_d = (level_d == PTR_ZERO);
    end
  end else begin : g_fwft
    // Two-stage prefetch: RAM read register (s1) feeds the output register, so a
    // fresh word reaches rd_data two edges after it is written and pops never bubble.
    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
    logic                  ram_has_s;
    logic                  out_load_s;
    logic                  s1_load_s;

    // Prefetch control and output register next state
    always_comb begin
      ram_has_s  = (wr_ptr_q != rd_ptr_q);
      out_load_s = s1_valid_q & (rd_empty_q | rd_acc_s);
      s1_load_s  = ram_has_s & (~s1_valid_q | out_load_s);
      rd_ptr_d   = rd_ptr_q;
      rd_data_d  = rd_data_q;
      rd_empty_d = rd_empty_q;
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      if (flush) begin
        rd_ptr_d   = PTR_ZERO;
        s1_valid_d = 1'b0;
        rd_empty_d = 1'b1;
      end else begin
        if (s1_load_s) begin
          rd_ptr_d   = rd_ptr_q + PTR_ONE;
          s1_data_d  = mem[rd_ptr_q[DEPTH_WIDTH-1:0]];
          s1_valid_d = 1'b1;
        end else if (out_load_s) begin
          s1_valid_d = 1'b0;
        end else begin
          s1_valid_d = s1_valid_q;
        end
        if (out_load_s) begin
          rd_data_d  = s1_data_q;
          rd_empty_d = 1'b0;
        end else if (rd_acc_s) begin
          rd_empty_d = 1'b1;
        end else begin
          rd_empty_d = rd_empty_q;
        end
      end
    end

    // Prefetch stage registers
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_valid_q <= 1'b0;
        s1_data_q  <= {DATA_WIDTH{1'b0}};
      end else begin
        s1_valid_q <= s1_valid_d;
        s1_data_q  <= s1_data_d;
      end
    end
  end

  // Pointer, level, output and flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q       <= PTR_ZERO;
      rd_ptr_q       <= PTR_ZERO;
      level_q        <= PTR_ZERO;
      rd_data_q      <= {DATA_WIDTH{1'b0}};
      rd_empty_q     <= 1'b1;
      wr_full_q      <= 1'b0;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      rd_data_q      <= rd_data_d;
      rd_empty_q     <= rd_empty_d;
      wr_full_q      <= wr_full_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  // Sample memory, no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem[wr_ptr_q[DEPTH_WIDTH-1:0]] <= wr_data;
    end
  end

  assign wr_full      = wr_full_q;
  assign almost_full  = almost_full_q;
  assign rd_data      = rd_data_q;
  assign rd_empty     = rd_empty_q;
  assign almost_empty = almost_empty_q;
  assign water_level  = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
